hazard_scheduler: RTL

//  Game-logic stage directly upstream of the VGA display controller. Runs the INIT/PLAY/FINISH

---
 rtl/hazard_scheduler.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_scheduler.sv
// Game FSM and per-round GAP/WARN/FIRE hazard sequencer for the 3x3 grid.
// Drives warning/fire/gold masks, life and score to the VGA display controller.
module hazard_scheduler #(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned GAP_TICKS  = 2,
    parameter int unsigned WARN_TICKS = 2,
    parameter int unsigned FIRE_TICKS = 2,
    parameter int unsigned LIFE_MAX   = 3,
    parameter int unsigned SCORE_MAX  = 5,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] box,
    output logic [1:0] game_state,
    output logic [8:0] warning_state,
    output logic [8:0] fire_state,
    output logic [8:0] gold_state,
    output logic [1:0] life,
    output logic [3:0] score,
    output logic       win
);

    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PCNT_W   = 8;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {
        G_INIT   = 2'b00,
        G_PLAY   = 2'b01,
        G_FINISH = 2'b10
    } game_e;

    typedef enum logic [1:0] {
        PH_GAP  = 2'd0,
        PH_WARN = 2'd1,
        PH_FIRE = 2'd2
    } phase_e;

    game_e              game_q,  game_d;
    phase_e             phase_q, phase_d;
    logic [TICK_W-1:0]  tick_q,  tick_d;
    logic [PCNT_W-1:0]  pcnt_q,  pcnt_d;
    logic [15:0]        lfsr_q,  lfsr_d;
    logic [8:0]         pat_q,   pat_d;
    logic [8:0]         gold_q,  gold_d;
    logic [8:0]         warn_q,  warn_d;
    logic [8:0]         fire_q,  fire_d;
    logic [1:0]         life_q,  life_d;
    logic [3:0]         score_q, score_d;
    logic               win_q,   win_d;
    logic               hit_q,   hit_d;

    logic               tick_c;
    logic [PCNT_W-1:0]  plast_c;
    logic [8:0]         pat_c;
    logic [8:0]         gold_c;
    logic [3:0]         gidx_c;
    logic [4:0]         pos_c;
    logic               found_c;

    assign tick_c = (tick_q == TICK_W'(TICK_DIV - 1));

    // Round draw from the current LFSR value: hazard pattern plus a coin cell outside it
    always_comb begin
        pat_c = lfsr_q[8:0] & lfsr_q[15:7];
        if (pat_c == 9'd0) begin
            pat_c = 9'(1) << (lfsr_q[3:0] % 4'd9);
        end
        if (pat_c == 9'h1FF) begin
            pat_c[4] = 1'b0;
        end
        gidx_c  = lfsr_q[15:12] % 4'd9;
        gold_c  = 9'd0;
        found_c = 1'b0;
        pos_c   = 5'd0;
        for (int k = 0; k < 9; k++) begin
            pos_c = 5'(gidx_c) + 5'(k);
            if (pos_c >= 5'd9) begin
                pos_c = pos_c - 5'd9;
            end
            if (!found_c && !pat_c[pos_c[3:0]]) begin
                gold_c[pos_c[3:0]] = 1'b1;
                found_c            = 1'b1;
            end
        end
    end

    always_comb begin
        case (phase_q)
            PH_GAP:  plast_c = PCNT_W'(GAP_TICKS - 1);
            PH_WARN: plast_c = PCNT_W'(WARN_TICKS - 1);
            PH_FIRE: plast_c = PCNT_W'(FIRE_TICKS - 1);
            default: plast_c = '0;
        endcase
    end

    // Next-state: game FSM, phase sequencing, collect/hit scoring
    always_comb begin
        game_d  = game_q;
        phase_d = phase_q;
        tick_d  = tick_c ? '0 : tick_q + TICK_W'(1);
        pcnt_d  = pcnt_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        pat_d   = pat_q;
        gold_d  = gold_q;
        warn_d  = warn_q;
        fire_d  = fire_q;
        life_d  = life_q;
        score_d = score_q;
        win_d   = win_q;
        hit_d   = hit_q;

        case (game_q)
            G_INIT, G_FINISH: begin
                warn_d = 9'd0;
                fire_d = 9'd0;
                gold_d = 9'd0;
                if (start) begin
                    game_d  = G_PLAY;
                    phase_d = PH_GAP;
                    pcnt_d  = '0;
                    tick_d  = '0;
                    life_d  = 2'(LIFE_MAX);
                    score_d = 4'd0;
                    win_d   = 1'b0;
                    hit_d   = 1'b0;
                    pat_d   = pat_c;
                    gold_d  = gold_c;
                end
            end
            G_PLAY: begin
                // Loss is checked first so a simultaneous final coin still ends as a loss
                if (life_q == 2'd0) begin
                    game_d = G_FINISH;
                    win_d  = 1'b0;
                    warn_d = 9'd0;
                    fire_d = 9'd0;
                    gold_d = 9'd0;
                end else if (score_q >= 4'(SCORE_MAX)) begin
                    game_d = G_FINISH;
                    win_d  = 1'b1;
                    warn_d = 9'd0;
                    fire_d = 9'd0;
                    gold_d = 9'd0;
                end else begin
                    if ((box & gold_q) != 9'd0) begin
                        gold_d = 9'd0;
                        if (score_q < 4'(SCORE_MAX)) begin
                            score_d = score_q + 4'd1;
                        end
                    end
                    if (phase_q == PH_FIRE && (box & fire_q) != 9'd0 && !hit_q) begin
                        hit_d = 1'b1;
                        if (life_q != 2'd0) begin
                            life_d = life_q - 2'd1;
                        end
                    end
                    if (tick_c) begin
                        if (pcnt_q == plast_c) begin
                            pcnt_d = '0;
                            case (phase_q)
                                PH_GAP: begin
                                    phase_d = PH_WARN;
                                    warn_d  = pat_q;
                                end
                                PH_WARN: begin
                                    phase_d = PH_FIRE;
                                    warn_d  = 9'd0;
                                    fire_d  = pat_q;
                                    hit_d   = 1'b0;
                                end
                                default: begin
                                    phase_d = PH_GAP;
                                    fire_d  = 9'd0;
                                    pat_d   = pat_c;
                                    gold_d  = gold_c;
                                end
                            endcase
                        end else begin
                            pcnt_d = pcnt_q + PCNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                game_d = G_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_q  <= G_INIT;
            phase_q <= PH_GAP;
            tick_q  <= '0;
            pcnt_q  <= '0;
            lfsr_q  <= SEED_EFF;
            pat_q   <= 9'd0;
            gold_q  <= 9'd0;
            warn_q  <= 9'd0;
            fire_q  <= 9'd0;
            life_q  <= 2'(LIFE_MAX);
            score_q <= 4'd0;
            win_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            game_q  <= game_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
            pcnt_q  <= pcnt_d;
            lfsr_q  <= lfsr_d;
            pat_q   <= pat_d;
            gold_q  <= gold_d;
            warn_q  <= warn_d;
            fire_q  <= fire_d;
            life_q  <= life_d;
            score_q <= score_d;
            win_q   <= win_d;
            hit_q   <= hit_d;
        end
    end

    assign game_state    = game_q;
    assign warning_state = warn_q;
    assign fire_state    = fire_q;
    assign gold_state    = gold_q;
    assign life          = life_q;
    assign score         = score_q;
    assign win           = win_q;

endmodule
